// File: rtl/i2c_target_responder.sv
// I2C target-side bit/byte engine: START/Sr/STOP detection, 7-bit address match,
// RX/TX FIFO handshakes and hold-timed open-drain SDA drive. Never stretches SCL.
module i2c_target_responder #(
   parameter int unsigned HdDatWidth    = 20,
   parameter logic [7:0]  UnderflowByte = 8'hFF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_o,
   input  logic [6:0]            target_addr_i,
   input  logic [HdDatWidth-1:0] t_hd_dat_i,
   output logic                  rx_wvalid_o,
   input  logic                  rx_wready_i,
   output logic [7:0]            rx_wdata_o,
   input  logic                  tx_rvalid_i,
   output logic                  tx_rready_o,
   input  logic [7:0]            tx_rdata_i,
   output logic                  start_det_o,
   output logic                  stop_det_o,
   output logic                  addr_match_o,
   output logic                  rnw_o,
   output logic                  rx_overflow_o,
   output logic                  tx_underflow_o,
   output logic                  busy_o
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_LOAD,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_e;

   state_e                  state_q, state_d;
   logic                    scl_q, sda_q;
   logic                    scl_rise, scl_fall, start_c, stop_c;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              shift_q, shift_d;
   logic [7:0]              byte_in, load_byte;
   logic                    phase_q, phase_d;
   logic                    ack_ok_q, ack_ok_d;
   logic                    pend_val_q, pend_val_d;
   logic                    pend_q;
   logic [HdDatWidth-1:0]   hold_cnt_q;
   logic                    rnw_d;
   logic                    push_d, ovf_d, match_d;
   logic                    in_load;

   assign scl_rise = scl_i & ~scl_q;
   assign scl_fall = ~scl_i & scl_q;
   assign start_c  = scl_q & scl_i & sda_q & ~sda_i;
   assign stop_c   = scl_q & scl_i & ~sda_q & sda_i;

   assign byte_in   = {shift_q[6:0], sda_i};
   assign load_byte = tx_rvalid_i ? tx_rdata_i : UnderflowByte;

   // The TX pop must land in the single RD_LOAD cycle, so these strobes are combinational.
   assign in_load        = (state_q == RD_LOAD) & enable_i & ~rst_i & ~start_c & ~stop_c;
   assign tx_rready_o    = in_load & tx_rvalid_i;
   assign tx_underflow_o = in_load & ~tx_rvalid_i;
   assign busy_o         = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_i;
         sda_q <= sda_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      phase_d    = phase_q;
      ack_ok_d   = ack_ok_q;
      pend_val_d = pend_val_q;
      rnw_d      = rnw_o;
      push_d     = 1'b0;
      ovf_d      = 1'b0;
      match_d    = 1'b0;

      if (scl_fall) pend_val_d = 1'b1;

      if (start_c) begin
         state_d    = ADDR;
         bit_cnt_d  = '0;
         pend_val_d = 1'b1;
      end else if (stop_c) begin
         state_d    = IDLE;
         pend_val_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (byte_in[7:1] == target_addr_i) begin
                        rnw_d    = byte_in[0];
                        match_d  = 1'b1;
                        ack_ok_d = 1'b1;
                        phase_d  = 1'b0;
                        state_d  = ADDR_ACK;
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            // phase 0: 8th fall schedules the ACK/NACK; phase 1: 9th fall releases it.
            ADDR_ACK, WR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     pend_val_d = ~ack_ok_q;
                     phase_d    = 1'b1;
                  end else begin
                     bit_cnt_d = '0;
                     state_d   = (state_q == ADDR_ACK && rnw_o) ? RD_LOAD : WR_DATA;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     phase_d  = 1'b0;
                     state_d  = WR_ACK;
                     ack_ok_d = rx_wready_i;
                     push_d   = rx_wready_i;
                     ovf_d    = ~rx_wready_i;
                  end
               end
            end
            // The hold counter was already loaded by the preceding fall; only its value is replaced here.
            RD_LOAD: begin
               shift_d    = load_byte;
               pend_val_d = load_byte[7];
               bit_cnt_d  = '0;
               state_d    = RD_DATA;
            end
            RD_DATA: begin
               if (scl_fall) begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     pend_val_d = 1'b1;
                     phase_d    = 1'b0;
                     state_d    = RD_ACK;
                  end else begin
                     pend_val_d = shift_q[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && !phase_q) begin
                  if (!sda_i) phase_d = 1'b1;
                  else        state_d = WAIT_STOP;
               end else if (scl_fall && phase_q) begin
                  state_d = RD_LOAD;
               end
            end
            WAIT_STOP: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !enable_i) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         phase_q       <= 1'b0;
         ack_ok_q      <= 1'b0;
         pend_val_q    <= 1'b1;
         pend_q        <= 1'b0;
         hold_cnt_q    <= '0;
         sda_o         <= 1'b1;
         rnw_o         <= 1'b0;
         rx_wvalid_o   <= 1'b0;
         rx_wdata_o    <= '0;
         rx_overflow_o <= 1'b0;
         addr_match_o  <= 1'b0;
         start_det_o   <= 1'b0;
         stop_det_o    <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         phase_q       <= phase_d;
         ack_ok_q      <= ack_ok_d;
         pend_val_q    <= pend_val_d;
         rnw_o         <= rnw_d;
         rx_wvalid_o   <= push_d;
         rx_overflow_o <= ovf_d;
         addr_match_o  <= match_d;
         start_det_o   <= start_c;
         stop_det_o    <= stop_c;
         if (push_d) rx_wdata_o <= byte_in;

         if (start_c || stop_c) begin
            sda_o  <= 1'b1;
            pend_q <= 1'b0;
         end else if (scl_fall && state_q != IDLE) begin
            hold_cnt_q <= t_hd_dat_i;
            pend_q     <= 1'b1;
         end else if (pend_q) begin
            if (hold_cnt_q == '0) begin
               sda_o  <= pend_val_d;
               pend_q <= 1'b0;
            end else begin
               hold_cnt_q <= hold_cnt_q - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C controller on a wired-AND SDA,
// directed scenarios plus randomized transactions checked against a transaction-level model.
module tb_i2c_target_responder;

   localparam int Q = 8;

   logic        clk = 1'b0;
   logic        rst_i, enable_i;
   logic        scl_drv, sda_ctl, sda_bus;
   logic        sda_o;
   logic [6:0]  target_addr_i;
   logic [19:0] t_hd_dat_i;
   logic        rx_wvalid_o, rx_wready_i;
   logic [7:0]  rx_wdata_o;
   logic        tx_rvalid_i, tx_rready_o;
   logic [7:0]  tx_rdata_i;
   logic        start_det_o, stop_det_o, addr_match_o, rnw_o;
   logic        rx_overflow_o, tx_underflow_o, busy_o;

   always #5 clk = ~clk;

   assign sda_bus = sda_ctl & sda_o;

   logic [7:0] tx_mem [16];
   logic [3:0] tx_wr = '0;
   logic [3:0] tx_rd = '0;
   assign tx_rvalid_i = (tx_wr != tx_rd);
   assign tx_rdata_i  = tx_mem[tx_rd];

   i2c_target_responder #(.HdDatWidth(20), .UnderflowByte(8'hFF)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .enable_i       (enable_i),
      .scl_i          (scl_drv),
      .sda_i          (sda_bus),
      .sda_o          (sda_o),
      .target_addr_i  (target_addr_i),
      .t_hd_dat_i     (t_hd_dat_i),
      .rx_wvalid_o    (rx_wvalid_o),
      .rx_wready_i    (rx_wready_i),
      .rx_wdata_o     (rx_wdata_o),
      .tx_rvalid_i    (tx_rvalid_i),
      .tx_rready_o    (tx_rready_o),
      .tx_rdata_i     (tx_rdata_i),
      .start_det_o    (start_det_o),
      .stop_det_o     (stop_det_o),
      .addr_match_o   (addr_match_o),
      .rnw_o          (rnw_o),
      .rx_overflow_o  (rx_overflow_o),
      .tx_underflow_o (tx_underflow_o),
      .busy_o         (busy_o)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   int         n_start = 0, n_stop = 0, n_match = 0, n_ovf = 0, n_uf = 0, n_pop = 0;
   logic [7:0] rx_got [$];
   logic [7:0] mdl_tx [$];
   logic [7:0] exp_rx [$];

   always @(negedge clk) begin
      if (rx_wvalid_o)    rx_got.push_back(rx_wdata_o);
      if (start_det_o)    n_start++;
      if (stop_det_o)     n_stop++;
      if (addr_match_o)   n_match++;
      if (rx_overflow_o)  n_ovf++;
      if (tx_underflow_o) n_uf++;
   end

   always @(posedge clk) begin
      if (tx_rready_o) begin
         tx_rd <= tx_rd + 4'd1;
         n_pop <= n_pop + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_mem[tx_wr] = b;
      tx_wr         = tx_wr + 4'd1;
      mdl_tx.push_back(b);
   endtask

   task automatic send_bit(input logic b, output logic seen);
      step(Q); sda_ctl = b;
      step(Q); scl_drv = 1'b1;
      step(Q); seen = sda_bus;
      step(Q); scl_drv = 1'b0;
   endtask

   task automatic bus_start();
      if (!scl_drv) begin
         step(Q); sda_ctl = 1'b1;
         step(Q); scl_drv = 1'b1;
      end
      step(Q); sda_ctl = 1'b0;
      step(Q); scl_drv = 1'b0;
   endtask

   task automatic bus_stop();
      step(Q); sda_ctl = 1'b0;
      step(Q); scl_drv = 1'b1;
      step(Q); sda_ctl = 1'b1;
      step(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         b[i] = s;
      end
      send_bit(mack, s);
   endtask

   initial begin
      logic       ack, s, hit, rdy, mack;
      logic [7:0] b, d, expb;
      logic [6:0] tgt, sent;
      int         r0, m0, o0, p0, u0, s0, e0, nb, k, m, exp_ovf, exp_pop, exp_uf;

      rst_i = 1'b1; enable_i = 1'b1; scl_drv = 1'b1; sda_ctl = 1'b1;
      target_addr_i = 7'h50; t_hd_dat_i = 20'd2; rx_wready_i = 1'b1;
      step(4);
      chk("rst_sda", sda_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_rnw", rnw_o, 0);
      chk("rst_rxv", rx_wvalid_o, 0);
      chk("rst_txr", tx_rready_o, 0);
      chk("rst_match", addr_match_o, 0);
      rst_i = 1'b0;
      step(4);

      // Matched write of two bytes
      t_hd_dat_i = 20'($urandom_range(0, 5));
      r0 = rx_got.size(); m0 = n_match; s0 = n_start; e0 = n_stop;
      bus_start();
      wr_byte({7'h50, 1'b0}, ack); chk("wr_addr_ack", ack, 0);
      chk("wr_match", n_match - m0, 1);
      chk("wr_rnw", rnw_o, 0);
      wr_byte(8'hA5, ack); chk("wr_d0_ack", ack, 0);
      wr_byte(8'h3C, ack); chk("wr_d1_ack", ack, 0);
      bus_stop(); step(4);
      chk("wr_npush", rx_got.size() - r0, 2);
      if (rx_got.size() - r0 == 2) begin
         chk("wr_rx0", rx_got[r0], 8'hA5);
         chk("wr_rx1", rx_got[r0+1], 8'h3C);
      end
      chk("wr_start", n_start - s0, 1);
      chk("wr_stop", n_stop - e0, 1);
      chk("wr_busy", busy_o, 0);

      // Address mismatch
      r0 = rx_got.size(); m0 = n_match;
      bus_start();
      wr_byte({7'h51, 1'b0}, ack); chk("mm_addr_nack", ack, 1);
      wr_byte(8'h55, ack); chk("mm_data_nack", ack, 1);
      chk("mm_busy", busy_o, 1);
      bus_stop(); step(4);
      chk("mm_match", n_match - m0, 0);
      chk("mm_npush", rx_got.size() - r0, 0);
      chk("mm_busy_end", busy_o, 0);

      // Read with TX data, ACK then NACK
      push_tx(8'h81); push_tx(8'h7E);
      p0 = n_pop; u0 = n_uf;
      bus_start();
      wr_byte({7'h50, 1'b1}, ack); chk("rd_addr_ack", ack, 0);
      chk("rd_rnw", rnw_o, 1);
      rd_byte(1'b0, b); chk("rd_b0", b, mdl_tx.pop_front());
      rd_byte(1'b1, b); chk("rd_b1", b, mdl_tx.pop_front());
      chk("rd_pops", n_pop - p0, 2);
      chk("rd_waitstop_busy", busy_o, 1);
      bus_stop(); step(4);
      chk("rd_uf", n_uf - u0, 0);
      chk("rd_busy_end", busy_o, 0);

      // Read with empty TX FIFO
      t_hd_dat_i = 20'($urandom_range(0, 5));
      p0 = n_pop; u0 = n_uf;
      bus_start();
      wr_byte({7'h50, 1'b1}, ack); chk("uf_addr_ack", ack, 0);
      rd_byte(1'b1, b); chk("uf_byte", b, 8'hFF);
      bus_stop(); step(4);
      chk("uf_count", n_uf - u0, 1);
      chk("uf_pops", n_pop - p0, 0);

      // RX overflow
      r0 = rx_got.size(); o0 = n_ovf;
      bus_start();
      wr_byte({7'h50, 1'b0}, ack); chk("ov_addr_ack", ack, 0);
      rx_wready_i = 1'b0;
      wr_byte(8'h11, ack); chk("ov_nack", ack, 1);
      rx_wready_i = 1'b1;
      bus_stop(); step(4);
      chk("ov_count", n_ovf - o0, 1);
      chk("ov_npush", rx_got.size() - r0, 0);

      // Repeated START after four data bits
      r0 = rx_got.size(); m0 = n_match; s0 = n_start;
      bus_start();
      wr_byte({7'h50, 1'b0}, ack); chk("sr_addr_ack", ack, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, s);
      bus_start(); step(2);
      chk("sr_start", n_start - s0, 2);
      chk("sr_busy", busy_o, 1);
      chk("sr_npush", rx_got.size() - r0, 0);
      wr_byte({7'h50, 1'b0}, ack); chk("sr_readdr_ack", ack, 0);
      chk("sr_match", n_match - m0, 2);
      bus_stop(); step(4);
      chk("sr_npush_end", rx_got.size() - r0, 0);

      // Hold timing: ACK drive 6 clk after SCL fall with t_hd_dat_i=5
      t_hd_dat_i = 20'd5;
      d = {7'h50, 1'b0};
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      step(6); chk("hd_before", sda_o, 1);
      step(1); chk("hd_at", sda_o, 0);
      step(1); sda_ctl = 1'b1;
      step(Q); scl_drv = 1'b1;
      step(Q); chk("hd_ack_bus", sda_bus, 0);
      step(Q); scl_drv = 1'b0;
      bus_stop(); step(4);

      // Reset during a read while SDA is driven low
      t_hd_dat_i = 20'($urandom_range(0, 5));
      push_tx(8'h00);
      bus_start();
      wr_byte({7'h50, 1'b1}, ack); chk("rr_addr_ack", ack, 0);
      step(Q); chk("rr_drive_low", sda_o, 0);
      void'(mdl_tx.pop_front());
      rst_i = 1'b1;
      step(1); chk("rr_sda_rel", sda_o, 1);
      chk("rr_busy", busy_o, 0);
      rst_i = 1'b0;
      bus_stop(); step(4);

      // Randomized writes, some with a wrong address
      for (int it = 0; it < 5; it++) begin
         tgt  = 7'($urandom_range(0, 127));
         hit  = ($urandom_range(0, 3) != 0);
         sent = hit ? tgt : (tgt ^ 7'(1 << $urandom_range(0, 6)));
         target_addr_i = tgt;
         t_hd_dat_i    = 20'($urandom_range(0, 5));
         r0 = rx_got.size(); m0 = n_match; o0 = n_ovf;
         exp_rx.delete(); exp_ovf = 0;
         bus_start();
         wr_byte({sent, 1'b0}, ack); chk("rw_addr_ack", ack, hit ? 0 : 1);
         nb = $urandom_range(1, 4);
         for (int j = 0; j < nb; j++) begin
            d   = 8'($urandom);
            rdy = 1'($urandom_range(0, 1));
            rx_wready_i = rdy;
            wr_byte(d, ack);
            chk("rw_data_ack", ack, (hit && rdy) ? 0 : 1);
            if (hit && rdy)  exp_rx.push_back(d);
            if (hit && !rdy) exp_ovf++;
         end
         rx_wready_i = 1'b1;
         bus_stop(); step(4);
         chk("rw_match", n_match - m0, hit ? 1 : 0);
         chk("rw_ovf", n_ovf - o0, exp_ovf);
         chk("rw_npush", rx_got.size() - r0, exp_rx.size());
         if (rx_got.size() - r0 == exp_rx.size())
            for (int j = 0; j < exp_rx.size(); j++) chk("rw_rx", rx_got[r0+j], exp_rx[j]);
      end

      // Randomized reads against the FIFO model; last byte NACKed
      target_addr_i = 7'h2A;
      for (int it = 0; it < 5; it++) begin
         k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) push_tx(8'($urandom));
         m = $urandom_range(1, 4);
         t_hd_dat_i = 20'($urandom_range(0, 5));
         p0 = n_pop; u0 = n_uf; exp_pop = 0; exp_uf = 0;
         bus_start();
         wr_byte({7'h2A, 1'b1}, ack); chk("rr_addr_ack", ack, 0);
         for (int j = 0; j < m; j++) begin
            mack = (j == m - 1);
            rd_byte(mack, b);
            if (mdl_tx.size() > 0) begin
               expb = mdl_tx.pop_front();
               exp_pop++;
            end else begin
               expb = 8'hFF;
               exp_uf++;
            end
            chk("rr_byte", b, expb);
         end
         bus_stop(); step(4);
         chk("rr_pops", n_pop - p0, exp_pop);
         chk("rr_uf", n_uf - u0, exp_uf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
